note_player_mc: RTL
===================

// Module: note_player_mc
// PURPOSE
//  Multi-channel successor to the single-voice note player. Holds NUM_CHANNELS
//  independent voices. Each voice has its own pitch, duration and instrument.
//  On each frame strobe, a sequencer walks the channels 0..N-1 in order and
//  shares one ROM port between them. For each channel it fetches the pitch
//  phase delta and the per-frame instrument envelope step.
//  Sits between the song sequencer (load side) and the oscillator/mixer bank
//  (phase/envelope outputs).
// PARAMETERS
//  NUM_CHANNELS    4   number of voices; channel index width CW = $clog2(NUM_CHANNELS), minimum 1
//  PHASE_WIDTH     32  phase delta width; fixed to two 16-bit ROM words
//  ENV_WIDTH       9   envelope output width; must be >= 4
//  ROM_ADDR_WIDTH  8   ROM address width
//  ROM_LATENCY     1   cycles from o_rom_addr valid to i_rom_data valid; range 1..3
// PORTS
//  i_clk           in   1                 clock
//  i_rst           in   1                 reset: synchronous, active-high
//  i_frame_stb     in   1                 frame tick; starts one channel scan
//  i_load          in   1                 queue a note for channel i_load_ch
//  i_load_ch       in   CW                target channel
//  i_pitch         in   6                 pitch index
//  i_duration      in   5                 extra frames after the first
//  i_instrument    in   4                 instrument index
//  o_busy          out  1                 scan in progress
//  o_update        out  1                 1-cycle pulse: scan done, outputs coherent
//  o_overrun       out  1                 1-cycle pulse: frame strobe dropped
//  o_done          out  NUM_CHANNELS      per-channel 1-cycle pulse: note finished
//  o_active        out  NUM_CHANNELS      per-channel voice sounding
//  o_phase_delta   out  NUM_CHANNELS*PHASE_WIDTH  channel c at [c*PW +: PW]
//  o_envelope      out  NUM_CHANNELS*ENV_WIDTH    channel c at [c*EW +: EW]
//  o_rom_addr      out  ROM_ADDR_WIDTH    shared ROM address, registered
//  i_rom_data      in   16                ROM data
// BEHAVIOUR
//  Reset values: all outputs 0; pending, active, step and remaining-frame
//   registers 0. Reset mid-scan aborts the scan immediately; no o_update.
//  ROM map:
//   pitch p: low word at 2p, high word at 2p+1.
//   Instrument lengths: word 0x80+i[3:2], nibble i[1:0].
//   Envelope values: word 0x84+4*i+s[3:2], nibble s[1:0].
//   Nibble 0 = bits[15:12] ... nibble 3 = bits[3:0].
//  Load: i_load sets pending[ch] and latches pitch, duration and instrument into
//   that channel's pending slot. Any cycle is legal. Last write before the
//   channel is serviced wins. An active note is retriggered.
//  A load coinciding with the scanner consuming pending[ch] stays pending for
//   the next frame; set has priority over clear.
//  FSM states: IDLE, CH_SELECT, RD_PLO, RD_PHI, RD_LEN, RD_ENV, CH_NEXT.
//  Each ROM read: drive the address, wait ROM_LATENCY cycles, capture the data.
//   Only one read is outstanding at a time.
//  IDLE: on i_frame_stb, ch=0, go to CH_SELECT, o_busy=1.
//  CH_SELECT, three cases:
//   pending: copy the slot to the live registers; step=0;
//    remaining=duration; clear pending. Then RD_PLO -> RD_PHI -> RD_LEN -> RD_ENV.
//   active && remaining==0: set active=0, phase delta=0, envelope=0,
//    pulse o_done[ch]. No ROM reads. Go to CH_NEXT.
//   active otherwise: remaining -= 1; step = min(step+1, len).
//    RD_ENV only. Holding the last step gives sustain.
//   inactive, not pending: go to CH_NEXT.
//  RD_ENV: envelope = {nibble, (ENV_WIDTH-4)'b0}; active=1.
//  CH_NEXT: if ch==NUM_CHANNELS-1, pulse o_update and go to IDLE (o_busy=0);
//   otherwise ch+=1 and go to CH_SELECT.
//  A channel's outputs change only while that channel is being serviced.
//  A note sounds for i_duration+1 frames. o_done fires on the following frame.
//  Frame strobe while o_busy: the strobe is dropped, o_overrun pulses, and the
//   scan continues unchanged.
//  Worst-case scan, all channels loading: N*(4*(1+ROM_LATENCY)+2) cycles.
//  o_rom_addr is a don't-care outside read states; drive 0.
// TESTING
//  1. Load ch0 p=5, d=2, instr=1; ROM[10]=0x1234, ROM[11]=0x0001, len nibble=3.
//     -> after the frame, phase0=0x0001_1234, active[0]=1, o_update once.
//  2. Env nibbles 0xF,0x8,0x4,0x2; len=2; d=5.
//     -> envelope per frame = 0x1E0,0x100,0x080,0x080,0x080,0x080, then o_done[0] and envelope 0.
//  3. Load ch1 and ch3 before the same frame, ROM_LATENCY=2.
//     -> ch1 is serviced before ch3; ch0 and ch2 outputs stay 0; o_busy length = 2*(4*3+2)+2*2 cycles.
//  4. i_frame_stb 3 cycles after the previous strobe, mid-scan.
//     -> o_overrun=1 for 1 cycle; exactly one o_update.
//  5. Load ch2 in the same cycle the scanner consumes ch2's pending.
//     -> new note starts next frame; i_rst mid-scan -> all outputs 0 next cycle.

Source files
------------

// File: rtl/note_player_mc_if.sv
// note_player_mc_if: shared ROM port between the note player and its ROM.
// The master drives a registered address; the slave returns data later.
interface note_player_mc_if #(
  parameter int ROM_ADDR_WIDTH = 8
);
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]               rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/note_player_mc.sv
// note_player_mc: multi-voice note player scanning channels per frame.
// One ROM port is shared; each channel fetches phase delta and envelope.
module note_player_mc #(
  parameter int NUM_CHANNELS   = 4,
  parameter int PHASE_WIDTH    = 32,
  parameter int ENV_WIDTH      = 9,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int ROM_LATENCY    = 1,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_frame_stb,
  input  logic                              i_load,
  input  logic [CW-1:0]                     i_load_ch,
  input  logic [5:0]                        i_pitch,
  input  logic [4:0]                        i_duration,
  input  logic [3:0]                        i_instrument,
  output logic                              o_busy,
  output logic                              o_update,
  output logic                              o_overrun,
  output logic [NUM_CHANNELS-1:0]           o_done,
  output logic [NUM_CHANNELS-1:0]           o_active,
  output logic [NUM_CHANNELS*PHASE_WIDTH-1:0] o_phase_delta,
  output logic [NUM_CHANNELS*ENV_WIDTH-1:0] o_envelope,
  note_player_mc_if.master                  rom
);

  typedef enum logic [2:0] {
    IDLE,
    CH_SELECT,
    RD_PLO,
    RD_PHI,
    RD_LEN,
    RD_ENV,
    CH_NEXT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]             ch_q;
  logic [1:0]                wait_q;
  logic [ROM_ADDR_WIDTH-1:0] addr_q;
  logic [ROM_ADDR_WIDTH-1:0] addr_d;

  logic [NUM_CHANNELS-1:0] pend_q;
  logic [5:0]              pend_pitch [NUM_CHANNELS];
  logic [4:0]              pend_dur   [NUM_CHANNELS];
  logic [3:0]              pend_ins   [NUM_CHANNELS];

  logic [5:0]             pitch_q [NUM_CHANNELS];
  logic [3:0]             ins_q   [NUM_CHANNELS];
  logic [3:0]             len_q   [NUM_CHANNELS];
  logic [3:0]             step_q  [NUM_CHANNELS];
  logic [4:0]             rem_q   [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_q [NUM_CHANNELS];
  logic [ENV_WIDTH-1:0]   env_q   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] act_q;

  logic [NUM_CHANNELS-1:0] done_q;
  logic                    upd_q;
  logic                    ovr_q;

  logic       cur_pend;
  logic       cur_act;
  logic [4:0] cur_rem;
  logic [3:0] step_inc;
  logic       is_rd;
  logic       rd_done;
  logic       is_last;
  logic       ld_ok;

  logic [ROM_ADDR_WIDTH-1:0] a_plo;
  logic [ROM_ADDR_WIDTH-1:0] a_phi;
  logic [ROM_ADDR_WIDTH-1:0] a_len;
  logic [ROM_ADDR_WIDTH-1:0] a_env0;
  logic [ROM_ADDR_WIDTH-1:0] a_envs;

  function automatic logic [3:0] nib(
    input logic [15:0] w,
    input logic [1:0]  s
  );
    logic [3:0] r;
    unique case (s)
      2'd0: r = w[15:12];
      2'd1: r = w[11:8];
      2'd2: r = w[7:4];
      default: r = w[3:0];
    endcase
    return r;
  endfunction

  assign cur_pend = pend_q[ch_q];
  assign cur_act  = act_q[ch_q];
  assign cur_rem  = rem_q[ch_q];
  assign is_last  = (ch_q == CW'(NUM_CHANNELS - 1));
  assign is_rd    = (state_q == RD_PLO) || (state_q == RD_PHI) ||
                    (state_q == RD_LEN) || (state_q == RD_ENV);
  assign rd_done  = is_rd && (wait_q == 2'(ROM_LATENCY));
  assign ld_ok    = ({1'b0, i_load_ch} < (CW+1)'(NUM_CHANNELS));

  assign step_inc = (step_q[ch_q] < len_q[ch_q]) ?
                    step_q[ch_q] + 4'd1 : len_q[ch_q];

  assign a_plo  = ROM_ADDR_WIDTH'({pend_pitch[ch_q], 1'b0});
  assign a_phi  = ROM_ADDR_WIDTH'({pitch_q[ch_q], 1'b1});
  assign a_len  = ROM_ADDR_WIDTH'(8'h80 + {6'd0, ins_q[ch_q][3:2]});
  assign a_env0 = ROM_ADDR_WIDTH'(8'h84 + {2'd0, ins_q[ch_q], 2'd0});
  assign a_envs = ROM_ADDR_WIDTH'(8'h84 + {2'd0, ins_q[ch_q], 2'd0} +
                                  {6'd0, step_inc[3:2]});

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the address for the read being entered.
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (i_frame_stb) state_d = CH_SELECT;
      end
      CH_SELECT: begin
        if (cur_pend) begin
          state_d = RD_PLO;
          addr_d  = a_plo;
        end else if (cur_act && (cur_rem != 5'd0)) begin
          state_d = RD_ENV;
          addr_d  = a_envs;
        end else begin
          state_d = CH_NEXT;
        end
      end
      RD_PLO: begin
        if (rd_done) begin
          state_d = RD_PHI;
          addr_d  = a_phi;
        end else begin
          addr_d  = addr_q;
        end
      end
      RD_PHI: begin
        if (rd_done) begin
          state_d = RD_LEN;
          addr_d  = a_len;
        end else begin
          addr_d  = addr_q;
        end
      end
      RD_LEN: begin
        if (rd_done) begin
          state_d = RD_ENV;
          addr_d  = a_env0;
        end else begin
          addr_d  = addr_q;
        end
      end
      RD_ENV: begin
        if (rd_done) begin
          state_d = CH_NEXT;
        end else begin
          addr_d  = addr_q;
        end
      end
      CH_NEXT: begin
        state_d = is_last ? IDLE : CH_SELECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel datapath: pending slots, live voice state and pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ch_q   <= '0;
      wait_q <= '0;
      addr_q <= '0;
      pend_q <= '0;
      act_q  <= '0;
      done_q <= '0;
      upd_q  <= 1'b0;
      ovr_q  <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        pend_pitch[c] <= '0;
        pend_dur[c]   <= '0;
        pend_ins[c]   <= '0;
        pitch_q[c]    <= '0;
        ins_q[c]      <= '0;
        len_q[c]      <= '0;
        step_q[c]     <= '0;
        rem_q[c]      <= '0;
        phase_q[c]    <= '0;
        env_q[c]      <= '0;
      end
    end else begin
      done_q <= '0;
      upd_q  <= 1'b0;
      ovr_q  <= (state_q != IDLE) && i_frame_stb;
      addr_q <= addr_d;
      wait_q <= (is_rd && !rd_done) ? wait_q + 2'd1 : 2'd0;
      unique case (state_q)
        IDLE: begin
          if (i_frame_stb) ch_q <= '0;
        end
        CH_SELECT: begin
          if (cur_pend) begin
            pitch_q[ch_q] <= pend_pitch[ch_q];
            ins_q[ch_q]   <= pend_ins[ch_q];
            rem_q[ch_q]   <= pend_dur[ch_q];
            step_q[ch_q]  <= 4'd0;
            pend_q[ch_q]  <= 1'b0;
          end else if (cur_act && (cur_rem == 5'd0)) begin
            act_q[ch_q]   <= 1'b0;
            phase_q[ch_q] <= '0;
            env_q[ch_q]   <= '0;
            done_q[ch_q]  <= 1'b1;
          end else if (cur_act) begin
            rem_q[ch_q]   <= cur_rem - 5'd1;
            step_q[ch_q]  <= step_inc;
          end
        end
        RD_PLO: begin
          if (rd_done) phase_q[ch_q][15:0] <= rom.rom_data;
        end
        RD_PHI: begin
          if (rd_done) phase_q[ch_q][31:16] <= rom.rom_data;
        end
        RD_LEN: begin
          if (rd_done) len_q[ch_q] <= nib(rom.rom_data, ins_q[ch_q][1:0]);
        end
        RD_ENV: begin
          if (rd_done) begin
            env_q[ch_q] <= ENV_WIDTH'(nib(rom.rom_data, step_q[ch_q][1:0]))
                           << (ENV_WIDTH - 4);
            act_q[ch_q] <= 1'b1;
          end
        end
        CH_NEXT: begin
          if (is_last) upd_q <= 1'b1;
          else         ch_q  <= ch_q + CW'(1);
        end
        default: ;
      endcase
      if (i_load && ld_ok) begin
        pend_q[i_load_ch]     <= 1'b1;
        pend_pitch[i_load_ch] <= i_pitch;
        pend_dur[i_load_ch]   <= i_duration;
        pend_ins[i_load_ch]   <= i_instrument;
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign o_phase_delta[c*PHASE_WIDTH +: PHASE_WIDTH] = phase_q[c];
    assign o_envelope[c*ENV_WIDTH +: ENV_WIDTH]        = env_q[c];
  end

  assign o_busy       = (state_q != IDLE);
  assign o_update     = upd_q;
  assign o_overrun    = ovr_q;
  assign o_done       = done_q;
  assign o_active     = act_q;
  assign rom.rom_addr = addr_q;

endmodule
